// File: rtl/seq_run_fsm.sv
// seq_run_fsm: one-hot run detector walking IDLE -> stage 1 .. STAGES (FINAL) on runs of `a`.
// Define SEQ_RUN_FSM_STICKY_EN to make FINAL sticky (left only by clear, reset or recovery).
module seq_run_fsm #(
  parameter int STAGES = 2,
  parameter int DWELL  = 1,
  parameter int GAP    = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        a,
  input  logic                        clear,
  output logic [STAGES:0]             state_oh,
  output logic [$clog2(STAGES+1)-1:0] stage_idx,
  output logic                        final_o,
  output logic                        final_pulse,
  output logic                        err
);

  localparam int IDX_W = $clog2(STAGES + 1);
  localparam int DW_W  = $clog2(DWELL + 1);
  localparam int GW_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [STAGES:0] IDLE_OH    = (STAGES + 1)'(1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [GW_W-1:0] GAP_LAST   = GW_W'(GAP);

`ifdef SEQ_RUN_FSM_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic [STAGES:0] state_q, state_d;
  logic [DW_W-1:0] dwell_cnt, dwell_d;
  logic [GW_W-1:0] gap_cnt, gap_d;
  logic            pulse_q, pulse_d;
  logic            err_q, err_d;
  logic            legal, in_idle, in_final;

  assign legal    = $onehot(state_q);
  assign in_idle  = state_q[0];
  assign in_final = state_q[STAGES];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_cnt;
    gap_d   = gap_cnt;
    err_d   = 1'b0;

    if (clear) begin
      state_d = IDLE_OH;
      dwell_d = '0;
      gap_d   = '0;
    end else if (!legal) begin
      state_d = IDLE_OH;
      dwell_d = '0;
      gap_d   = '0;
      err_d   = 1'b1;
    end else if (a) begin
      gap_d = '0;
      if (in_final) begin
        dwell_d = '0;
      end else if (dwell_cnt == DWELL_LAST) begin
        state_d = state_q << 1;
        dwell_d = '0;
      end else begin
        dwell_d = dwell_cnt + 1'b1;
      end
    end else begin
      // A low sample breaks the run, so the stage must be re-earned from scratch.
      dwell_d = '0;
      if (in_idle) begin
        gap_d = '0;
      end else if (STICKY && in_final) begin
        gap_d = gap_cnt;
      end else if (gap_cnt == GAP_LAST) begin
        state_d = IDLE_OH;
        gap_d   = '0;
      end else begin
        gap_d = gap_cnt + 1'b1;
      end
    end

    pulse_d = state_d[STAGES] & ~state_q[STAGES];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all state, counters included, is reset so the machine never starts in an illegal encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE_OH;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_cnt <= dwell_d;
      gap_cnt   <= gap_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    stage_idx = '0;
    for (int k = 0; k <= STAGES; k++) begin
      if (state_q[k]) stage_idx = IDX_W'(k);
    end
  end

  assign state_oh    = state_q;
  assign final_o     = in_final;
  assign final_pulse = pulse_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seq_run_fsm.sv
// Bench for seq_run_fsm: four parameterisations share one stimulus stream, each checked
// every cycle against a run-length model, plus hand-computed directed expectations.
module tb_seq_run_fsm;

  localparam int NI = 4;
  localparam int P_S[NI] = '{2, 3, 2, 1};
  localparam int P_D[NI] = '{1, 2, 1, 3};
  localparam int P_G[NI] = '{0, 0, 2, 1};

`ifdef SEQ_RUN_FSM_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, a, clear;
  bit   illegal0;

  logic [2:0] oh0;  logic [1:0] idx0;  logic fin0, fp0, err0;
  logic [3:0] oh1;  logic [1:0] idx1;  logic fin1, fp1, err1;
  logic [2:0] oh2;  logic [1:0] idx2;  logic fin2, fp2, err2;
  logic [1:0] oh3;  logic [0:0] idx3;  logic fin3, fp3, err3;

  seq_run_fsm #(.STAGES(2), .DWELL(1), .GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a), .clear(clear), .state_oh(oh0), .stage_idx(idx0),
    .final_o(fin0), .final_pulse(fp0), .err(err0));
  seq_run_fsm #(.STAGES(3), .DWELL(2), .GAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a), .clear(clear), .state_oh(oh1), .stage_idx(idx1),
    .final_o(fin1), .final_pulse(fp1), .err(err1));
  seq_run_fsm #(.STAGES(2), .DWELL(1), .GAP(2)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a), .clear(clear), .state_oh(oh2), .stage_idx(idx2),
    .final_o(fin2), .final_pulse(fp2), .err(err2));
  seq_run_fsm #(.STAGES(1), .DWELL(3), .GAP(1)) u3 (
    .clk(clk), .rst_n(rst_n), .a(a), .clear(clear), .state_oh(oh3), .stage_idx(idx3),
    .final_o(fin3), .final_pulse(fp3), .err(err3));

  logic [14:0] act[NI];
  assign act[0] = {8'(oh0), 4'(idx0), fin0, fp0, err0};
  assign act[1] = {8'(oh1), 4'(idx1), fin1, fp1, err1};
  assign act[2] = {8'(oh2), 4'(idx2), fin2, fp2, err2};
  assign act[3] = {8'(oh3), 4'(idx3), fin3, fp3, err3};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: stage number, length of the current high run within the stage, length of the low run.
  int m_stage[NI], m_run[NI], m_low[NI];
  bit m_fp[NI], m_err[NI];

  task automatic model_reset(input int i);
    m_stage[i] = 0; m_run[i] = 0; m_low[i] = 0; m_fp[i] = 0; m_err[i] = 0;
  endtask

  task automatic model_step(input int i, input bit av, input bit cv, input bit ill);
    bit was_final;
    was_final = (m_stage[i] == P_S[i]);
    m_err[i]  = 0;
    if (cv || ill) begin
      m_stage[i] = 0; m_run[i] = 0; m_low[i] = 0;
      m_err[i]   = ill && !cv;
    end else if (av) begin
      m_low[i] = 0;
      m_run[i] = was_final ? 0 : m_run[i] + 1;
      if (m_run[i] == P_D[i]) begin
        m_stage[i]++;
        m_run[i] = 0;
      end
    end else begin
      m_run[i] = 0;
      if (m_stage[i] == 0) m_low[i] = 0;
      else if (!(STICKY && was_final)) begin
        m_low[i]++;
        if (m_low[i] > P_G[i]) begin
          m_stage[i] = 0;
          m_low[i]   = 0;
        end
      end
    end
    m_fp[i] = (m_stage[i] == P_S[i]) && !was_final;
  endtask

  function automatic logic [14:0] expected(input int i);
    logic [7:0] oh;
    oh = 8'(1) << m_stage[i];
    return {oh, 4'(m_stage[i]), m_stage[i] == P_S[i], m_fp[i], m_err[i]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) model_reset(i);
      else model_step(i, a, clear, (i == 0) && illegal0);
    end
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("u%0d_outputs", i), 32'(act[i]), 32'(expected(i)));
  end

  task automatic cyc(input bit av, input bit cv);
    a = av;
    clear = cv;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int thr;
    a = 0; clear = 0; rst_n = 0; illegal0 = 0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_state_oh", oh0, 3'b001);
    check("reset_stage_idx", idx1, 0);
    check("reset_final_o", fin0, 0);
    check("reset_final_pulse", fp0, 0);
    check("reset_err", err0, 0);
    rst_n = 1;

    // Fixed-detector equivalence: 1,1,1,0 on STAGES=2 DWELL=1 GAP=0
    cyc(1, 0); check("t1_stage1", oh0, 3'b010);
    cyc(1, 0); check("t1_final", oh0, 3'b100); check("t1_pulse_rise", fp0, 1); check("t1_final_o", fin0, 1);
    cyc(1, 0); check("t1_final_hold", oh0, 3'b100); check("t1_pulse_fall", fp0, 0);
    cyc(0, 0); check("t1_low", oh0, STICKY ? 3'b100 : 3'b001);

    // DWELL=2 on three stages: broken run restarts from IDLE, FINAL after 6 highs
    cyc(0, 1);
    cyc(1, 0); check("t2_one_high", idx1, 0);
    cyc(1, 0); check("t2_stage1", idx1, 1);
    cyc(1, 0); check("t2_stage1_hold", idx1, 1);
    cyc(0, 0); check("t2_low_idle", idx1, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 0);
      if (k == 5) check("t2_stage2", idx1, 2);
      if (k == 6) begin
        check("t2_final_idx", idx1, 3);
        check("t2_final_pulse", fp1, 1);
      end
    end

    // GAP=2 tolerance while in FINAL
    cyc(0, 1);
    cyc(1, 0);
    cyc(1, 0); check("t3_final", fin2, 1); check("t3_pulse", fp2, 1);
    cyc(0, 0); check("t3_gap1", fin2, 1);
    cyc(0, 0); check("t3_gap2", fin2, 1);
    cyc(1, 0); check("t3_refill", fin2, 1);
    cyc(0, 0);
    cyc(0, 0); check("t3_two_lows", fin2, 1);
    cyc(0, 0); check("t3_third_low", oh2, STICKY ? 3'b100 : 3'b001);
    check("t3_err", err2, 0);

    // clear with a=1 wins and the high is not counted; then async reset mid-cycle
    cyc(0, 1);
    cyc(1, 0);
    cyc(1, 0); check("t4_stage1", idx1, 1);
    cyc(1, 1); check("t4_clear_idle", oh1, 4'b0001); check("t4_dwell_zero", u1.dwell_cnt, 0);
    cyc(1, 0); check("t4_not_counted", idx1, 0);
    cyc(1, 0); check("t4_restage", idx1, 1); check("t4_u0_pulse", fp0, 1);
    #1 rst_n = 0;
    #1;
    check("t4_async_oh", oh0, 3'b001);
    check("t4_async_final_o", fin0, 0);
    check("t4_async_pulse", fp0, 0);
    check("t4_async_idx", idx1, 0);
    @(posedge clk);
    #2 rst_n = 1;

    // Illegal-state recovery
    cyc(1, 0); check("t5_stage1", oh0, 3'b010);
    @(negedge clk);
    force u0.state_q = 3'b011;
    illegal0 = 1;
    #1 release u0.state_q;
    @(posedge clk);
    #2 illegal0 = 0;
    check("t5_recover_oh", oh0, 3'b001); check("t5_err_set", err0, 1);
    cyc(0, 0); check("t5_err_clear", err0, 0); check("t5_idle", oh0, 3'b001);

    // Sticky FINAL (or exit on first low without the option)
    cyc(0, 1);
    cyc(1, 0);
    cyc(1, 0); check("t6_final", fin0, 1);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0);
      check("t6_low_hold", fin0, STICKY);
    end
    cyc(0, 1); check("t6_clear", oh0, 3'b001);

    // STAGES=1: IDLE straight to FINAL after DWELL=3 highs
    cyc(1, 0);
    cyc(1, 0); check("t7_not_yet", oh3, 2'b01);
    cyc(1, 0); check("t7_final", oh3, 2'b10); check("t7_pulse", fp3, 1);
    cyc(0, 0); check("t7_gap1", oh3, 2'b10);
    cyc(0, 0); check("t7_gap2", oh3, STICKY ? 2'b10 : 2'b01);

    // Randomised runs with varying density and rare clears
    thr = 8;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) thr = int'($urandom_range(15, 6));
      cyc(int'($urandom_range(15, 0)) < thr, $urandom_range(63, 0) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_run_fsm.md
# seq_run_fsm

Parametrised one-hot sequence FSM: a run of consecutive `a` assertions walks the machine from IDLE through STAGES stages, and it stays in the last stage (FINAL) while the run continues. Each stage requires DWELL consecutive high cycles before advancing. Up to GAP consecutive low cycles are tolerated before the machine falls back to IDLE. It is the general replacement for the fixed two-stage IDLE/STATE_1/FINAL detector and drives per-stage status to downstream control logic.

## Interface
- STAGES, 2, number of non-IDLE states; the last one is FINAL; legal range ≥1.
- DWELL, 1, consecutive `a`=1 cycles required to advance one stage; legal range ≥1.
- GAP, 0, consecutive `a`=0 cycles tolerated without dropping to IDLE; legal range ≥0.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  1  run input, sampled each rising edge.
- clear  in  1  synchronous force-to-IDLE.
- state_oh  out  STAGES+1  one-hot state; bit 0 = IDLE, bit k = stage k, bit STAGES = FINAL.
- stage_idx  out  $clog2(STAGES+1)  binary index of the current state.
- final_o  out  1  high while in FINAL.
- final_pulse  out  1  one-cycle strobe in the first cycle FINAL is visible.
- err  out  1  one-cycle strobe after recovery from a non-one-hot state.

## Operation
- The state register is one-hot, STAGES+1 bits.
- All outputs are registered or decoded directly from registers. None depend combinationally on `a` or `clear`.
- Internal counters:
  - dwell_cnt, width $clog2(DWELL+1), min 1: counts consecutive `a`=1 cycles in the current stage.
  - gap_cnt, width $clog2(GAP+1), min 1: counts consecutive `a`=0 cycles.
- Next-state priority, highest first: rst_n low > clear > illegal-state recovery > normal transition.
- `a`=1, not in FINAL:
  - gap_cnt is cleared.
  - If dwell_cnt==DWELL-1, advance one stage and clear dwell_cnt.
  - Otherwise increment dwell_cnt.
- `a`=1 in FINAL: stay in FINAL, counters cleared.
- `a`=0 in IDLE: stay in IDLE, counters cleared.
- `a`=0 elsewhere:
  - dwell_cnt is cleared, so a run must restart within the stage.
  - If gap_cnt==GAP, go to IDLE and clear gap_cnt.
  - Otherwise hold the state and increment gap_cnt.
- clear=1 forces IDLE and zeroes both counters, regardless of `a`.
- Illegal state means state_oh is not exactly one-hot. The next edge loads IDLE, zeroes the counters and sets err=1 for one cycle.
- final_pulse is set on the edge where next state is FINAL and current state is not FINAL. It is cleared on the following edge.

## Timing
- Reset values:
  - state_oh = 1 (IDLE)
  - stage_idx = 0
  - final_o = 0
  - final_pulse = 0
  - err = 0
  - both counters = 0
- Asserting rst_n mid-run returns all of the above at once, without waiting for a clock edge.
- Minimum latency from IDLE to FINAL is STAGES×DWELL consecutive high samples. FINAL is visible in the cycle after the last of those samples.
- With DWELL=1 and GAP=0, behaviour is cycle-identical to the fixed detector:
  - `a` high at edge n gives stage 1 after edge n.
  - Any low sample returns the machine to IDLE after that edge.
- A drop to IDLE happens on the edge that samples the (GAP+1)-th consecutive low.
- final_pulse and final_o rise together. final_pulse is exactly one cycle wide even if FINAL is held.
- Re-entry to FINAL after leaving it produces a new final_pulse.
- clear and `a`=1 on the same edge: IDLE wins, and `a` is not counted.
- STAGES=1: IDLE goes directly to FINAL.

## Configuration
- Macro: SEQ_RUN_FSM_STICKY_EN.
- Defined: FINAL is sticky.
  - Only clear, rst_n or illegal-state recovery leave FINAL.
  - `a`=0 in FINAL holds FINAL and does not advance gap_cnt.
  - All other stages behave as in Operation.
- Undefined: FINAL exits to IDLE on gap exhaustion, exactly like the other stages.

## Test plan
- STAGES=2, DWELL=1, GAP=0; `a` = 1,1,1,0 → state_oh 001→010→100→100→001; final_pulse high only in the first 100 cycle.
- STAGES=3, DWELL=2, GAP=0; `a` = 1,1,1,0,1,1,1,1,1,1 → reaches stage 1 after the 2nd high; the 0 returns to IDLE; FINAL (stage_idx=3) after the 6th consecutive high.
- STAGES=2, DWELL=1, GAP=2; in FINAL, `a` = 0,0,1 → FINAL held; `a` = 0,0,0 → IDLE after the 3rd low; err stays 0.
- Drive clear=1 with `a`=1 while in stage 1 → IDLE next cycle, dwell_cnt=0; then pull rst_n low mid-cycle → outputs immediately at reset values.
- Force state_oh=3'b011 → next edge state_oh=001, err=1 for exactly one cycle.
- SEQ_RUN_FSM_STICKY_EN defined; reach FINAL, then hold `a`=0 for 10 cycles → final_o stays 1; clear → IDLE. Without the macro, GAP=0 → IDLE after the first low.
